// File: rtl/log_ctrl_pkg.sv
// Shared encodings and default sizing for the capture-buffer controller.
package log_ctrl_pkg;

    localparam int unsigned RAM_DEPTH_DEFAULT = 32768;
    localparam int unsigned N_DELAY_DEFAULT   = 500;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE = 2'd0,
        TRIG_EDGE      = 2'd1,
        TRIG_LEVEL     = 2'd2,
        TRIG_RESERVED  = 2'd3
    } trig_mode_t;

endpackage

// File: rtl/log_capture_ctrl.sv
// Arm/trigger/holdoff/capture controller that drives the write and readout
// ports of a single-port log RAM so the two never collide.
module log_capture_ctrl
    import log_ctrl_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEFAULT,
    parameter int unsigned N_DELAY   = N_DELAY_DEFAULT,
    localparam int unsigned AW       = $clog2(RAM_DEPTH)
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_arm,
    input  logic          i_abort,
    input  logic [1:0]    i_trig_mode,
    input  logic          i_trigger,
    input  logic          i_sample_valid,
    input  logic [AW:0]   i_length,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_adrs,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_adrs,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_adrs,
    output logic [2:0]    o_state,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW:0]   o_count
);

    localparam int unsigned LW        = AW + 1;
    localparam int unsigned HW        = (N_DELAY < 2) ? 1 : $clog2(N_DELAY);
    localparam int unsigned HOLD_LAST = (N_DELAY == 0) ? 0 : N_DELAY - 1;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_trig_prev;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_count;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_adrs;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_adrs;
    logic            r_busy;
    logic            r_done;

    logic            w_trig_hit;
    logic [LW-1:0]   w_len_eff;
    logic            w_arm_ok;
    logic            w_hold_done;
    logic            w_wr_fire;
    logic            w_last_wr;
    logic            w_rd_fire;
    logic            w_idle_or_done;

    // State register
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every transition including arm
    always_comb begin
        w_next_state = r_state;
        if (i_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_arm) w_next_state = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_trig_hit) w_next_state = (N_DELAY == 0) ? ST_CAPTURE : ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (w_hold_done) w_next_state = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (w_wr_fire && w_last_wr) w_next_state = ST_DONE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Control decode feeding the registered outputs and counters
    always_comb begin
        w_trig_hit     = 1'b1;
        w_len_eff      = i_length;
        w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
        w_arm_ok       = 1'b0;
        w_hold_done    = 1'b0;
        w_wr_fire      = 1'b0;
        w_last_wr      = 1'b0;
        w_rd_fire      = 1'b0;

        case (trig_mode_t'(i_trig_mode))
            TRIG_EDGE:  w_trig_hit = i_trigger & ~r_trig_prev;
            TRIG_LEVEL: w_trig_hit = i_trigger;
            default:    w_trig_hit = 1'b1;
        endcase

        if ((i_length == '0) || (i_length > LW'(RAM_DEPTH))) begin
            w_len_eff = LW'(RAM_DEPTH);
        end

        w_arm_ok    = i_arm & ~i_abort & w_idle_or_done;
        w_hold_done = (r_state == ST_HOLDOFF) & i_sample_valid &
                      (r_hold_cnt == HW'(HOLD_LAST));
        w_wr_fire   = (r_state == ST_CAPTURE) & i_sample_valid & ~i_abort;
        w_last_wr   = ((r_count + LW'(1)) == r_len);
        w_rd_fire   = i_rd_req & w_idle_or_done;
    end

    // Counters, trigger history and registered RAM port signals
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_trig_prev <= 1'b0;
            r_len       <= '0;
            r_count     <= '0;
            r_hold_cnt  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_adrs   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_adrs   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_trig_prev <= i_trigger;
            r_wr_en     <= w_wr_fire;
            r_rd_en     <= w_rd_fire;
            r_rd_adrs   <= i_rd_adrs;
            r_busy      <= (w_next_state == ST_ARMED) || (w_next_state == ST_HOLDOFF) ||
                           (w_next_state == ST_CAPTURE);
            r_done      <= (w_next_state == ST_DONE);

            if (w_arm_ok) begin
                r_len     <= w_len_eff;
                r_count   <= '0;
                r_wr_adrs <= '0;
            end

            // r_count doubles as the write pointer; the FSM leaves CAPTURE
            // on the last write so it never reaches a wrapping value
            if (w_wr_fire) begin
                r_wr_adrs <= r_count[AW-1:0];
                r_count   <= r_count + LW'(1);
            end

            if (r_state == ST_ARMED) begin
                r_hold_cnt <= '0;
            end else if ((r_state == ST_HOLDOFF) && i_sample_valid) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_adrs = r_wr_adrs;
    assign o_rd_en   = r_rd_en;
    assign o_rd_adrs = r_rd_adrs;
    assign o_state   = r_state;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_count   = r_count;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Two controller instances (holdoff 0 and 3) on shared stimulus, checked every
// cycle against a transaction-level model plus directed literal expectations.
module tb_log_capture_ctrl;
    import log_ctrl_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int          ND0   = 0;
    localparam int          ND1   = 3;

    typedef struct packed {
        logic          wr_en;
        logic [AW-1:0] wr_adrs;
        logic          rd_en;
        logic [AW-1:0] rd_adrs;
        logic [2:0]    state;
        logic          busy;
        logic          done;
        logic [AW:0]   count;
    } obs_t;

    typedef struct {
        int st;
        int len;
        int cnt;
        int hold;
        bit prev;
        bit wr_en;
        int wr_adrs;
        bit rd_en;
        int rd_adrs;
    } mdl_t;

    logic          clk            = 1'b0;
    logic          i_reset        = 1'b0;
    logic          i_arm          = 1'b0;
    logic          i_abort        = 1'b0;
    logic [1:0]    i_trig_mode    = 2'd0;
    logic          i_trigger      = 1'b0;
    logic          i_sample_valid = 1'b0;
    logic [AW:0]   i_length       = '0;
    logic          i_rd_req       = 1'b0;
    logic [AW-1:0] i_rd_adrs      = '0;

    logic          d0_wr_en, d0_rd_en, d0_busy, d0_done;
    logic [AW-1:0] d0_wr_adrs, d0_rd_adrs;
    logic [2:0]    d0_state;
    logic [AW:0]   d0_count;
    logic          d1_wr_en, d1_rd_en, d1_busy, d1_done;
    logic [AW-1:0] d1_wr_adrs, d1_rd_adrs;
    logic [2:0]    d1_state;
    logic [AW:0]   d1_count;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   chk_en   = 1'b0;
    mdl_t m [2];
    int   wq0[$], wc0[$], wq1[$];

    always #5 clk = ~clk;

    log_capture_ctrl #(.RAM_DEPTH(DEPTH), .N_DELAY(ND0)) u_dut0 (
        .clk(clk), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
        .i_trig_mode(i_trig_mode), .i_trigger(i_trigger), .i_sample_valid(i_sample_valid),
        .i_length(i_length), .i_rd_req(i_rd_req), .i_rd_adrs(i_rd_adrs),
        .o_wr_en(d0_wr_en), .o_wr_adrs(d0_wr_adrs), .o_rd_en(d0_rd_en), .o_rd_adrs(d0_rd_adrs),
        .o_state(d0_state), .o_busy(d0_busy), .o_done(d0_done), .o_count(d0_count)
    );

    log_capture_ctrl #(.RAM_DEPTH(DEPTH), .N_DELAY(ND1)) u_dut1 (
        .clk(clk), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
        .i_trig_mode(i_trig_mode), .i_trigger(i_trigger), .i_sample_valid(i_sample_valid),
        .i_length(i_length), .i_rd_req(i_rd_req), .i_rd_adrs(i_rd_adrs),
        .o_wr_en(d1_wr_en), .o_wr_adrs(d1_wr_adrs), .o_rd_en(d1_rd_en), .o_rd_adrs(d1_rd_adrs),
        .o_state(d1_state), .o_busy(d1_busy), .o_done(d1_done), .o_count(d1_count)
    );

    function automatic obs_t obs(int k);
        obs_t r;
        if (k == 0) r = {d0_wr_en, d0_wr_adrs, d0_rd_en, d0_rd_adrs, d0_state, d0_busy, d0_done, d0_count};
        else        r = {d1_wr_en, d1_wr_adrs, d1_rd_en, d1_rd_adrs, d1_state, d1_busy, d1_done, d1_count};
        return r;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Behavioural reference: one capture transaction per arm, in plain integers
    task automatic model_step(int k);
        int   nd = (k == 0) ? ND0 : ND1;
        mdl_t s  = m[k];
        mdl_t n  = m[k];
        bit   hit;
        n.wr_en   = 1'b0;
        n.rd_en   = i_rd_req && (s.st == 0 || s.st == 4);
        n.rd_adrs = int'(i_rd_adrs);
        n.prev    = i_trigger;
        if (i_abort) begin
            n.st = 0;
        end else begin
            case (s.st)
                0, 4: if (i_arm) begin
                    n.st      = 1;
                    n.len     = (i_length == 0 || int'(i_length) > DEPTH) ? DEPTH : int'(i_length);
                    n.cnt     = 0;
                    n.wr_adrs = 0;
                end
                1: begin
                    if (i_trig_mode == 2'd1)      hit = i_trigger && !s.prev;
                    else if (i_trig_mode == 2'd2) hit = i_trigger;
                    else                          hit = 1'b1;
                    if (hit) begin
                        if (nd == 0) n.st = 3;
                        else begin
                            n.st   = 2;
                            n.hold = 0;
                        end
                    end
                end
                2: if (i_sample_valid) begin
                    n.hold = s.hold + 1;
                    if (n.hold == nd) n.st = 3;
                end
                3: if (i_sample_valid) begin
                    n.wr_en   = 1'b1;
                    n.wr_adrs = s.cnt;
                    n.cnt     = s.cnt + 1;
                    if (n.cnt == s.len) n.st = 4;
                end
                default: n.st = 0;
            endcase
        end
        m[k] = n;
    endtask

    always @(posedge clk or negedge i_reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!i_reset) m[k] = '{default: 0};
            else          model_step(k);
        end
    end

    always @(posedge clk) begin
        cyc++;
        chk_en = 1'b1;
        #1;
        if (d0_wr_en) begin
            wq0.push_back(int'(d0_wr_adrs));
            wc0.push_back(cyc);
        end
        if (d1_wr_en) wq1.push_back(int'(d1_wr_adrs));
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        obs_t a;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                a = obs(k);
                check($sformatf("dut%0d.state", k), int'(a.state), m[k].st);
                check($sformatf("dut%0d.busy", k), int'(a.busy), int'(m[k].st >= 1 && m[k].st <= 3));
                check($sformatf("dut%0d.done", k), int'(a.done), int'(m[k].st == 4));
                check($sformatf("dut%0d.count", k), int'(a.count), m[k].cnt);
                check($sformatf("dut%0d.wr_en", k), int'(a.wr_en), int'(m[k].wr_en));
                if (m[k].wr_en) check($sformatf("dut%0d.wr_adrs", k), int'(a.wr_adrs), m[k].wr_adrs);
                check($sformatf("dut%0d.rd_en", k), int'(a.rd_en), int'(m[k].rd_en));
                check($sformatf("dut%0d.rd_adrs", k), int'(a.rd_adrs), m[k].rd_adrs);
                check($sformatf("dut%0d.wr_rd_excl", k), int'(a.wr_en & a.rd_en), 0);
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm();
        i_arm = 1'b1;
        @(negedge clk);
        i_arm = 1'b0;
    endtask

    task automatic pulse_abort();
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
    endtask

    task automatic wait_done(int k, int lim, string nm);
        int i = 0;
        while (!((k == 0) ? d0_done : d1_done) && i < lim) begin
            @(negedge clk);
            i++;
        end
        check(nm, int'((k == 0) ? d0_done : d1_done), 1);
    endtask

    task automatic wait_writes(int n, int lim, string nm);
        int i = 0;
        while (wq0.size() < n && i < lim) begin
            @(negedge clk);
            i++;
        end
        check(nm, wq0.size(), n);
    endtask

    function automatic int seq_errs0(int n);
        int e = 0;
        for (int i = 0; i < wq0.size() && i < n; i++) if (wq0[i] != i) e++;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        i_reset = 1'b1;
        cycles(1);
        check("reset.state", int'(d0_state), 0);
        check("reset.count", int'(d0_count), 0);
        check("reset.busy", int'(d1_busy), 0);

        // Immediate trigger, length 4, valid every cycle
        i_sample_valid = 1'b1;
        i_trig_mode    = 2'd0;
        i_length       = 5'd4;
        wq0.delete(); wc0.delete();
        pulse_arm();
        wait_done(0, 20, "s1.done");
        check("s1.nwrites", wq0.size(), 4);
        check("s1.order", seq_errs0(4), 0);
        if (wc0.size() == 4) check("s1.consecutive", wc0[3] - wc0[0], 3);
        check("s1.count", int'(d0_count), 4);
        check("s1.state", int'(d0_state), 4);
        wait_done(1, 20, "s1.done1");
        pulse_abort();

        // Edge trigger: high level before arm is not an edge
        i_sample_valid = 1'b0;
        i_trig_mode    = 2'd1;
        i_trigger      = 1'b1;
        cycles(2);
        pulse_arm();
        cycles(3);
        check("s2.no_trig0", int'(d0_state), 1);
        check("s2.no_trig1", int'(d1_state), 1);
        i_trigger = 1'b0;
        cycles(1);
        i_trigger = 1'b1;
        cycles(1);
        check("s2.holdoff", int'(d1_state), 2);
        check("s2.capture0", int'(d0_state), 3);
        wq1.delete();
        for (int p = 0; p < 3; p++) begin
            i_sample_valid = 1'b1;
            cycles(1);
            i_sample_valid = 1'b0;
            check($sformatf("s2.pulse%0d_state", p), int'(d1_state), (p < 2) ? 2 : 3);
            cycles(1);
        end
        check("s2.no_early_wr", wq1.size(), 0);
        i_sample_valid = 1'b1;
        cycles(1);
        i_sample_valid = 1'b0;
        check("s2.first_wr", int'(d1_wr_en), 1);
        check("s2.first_adrs", int'(d1_wr_adrs), 0);
        pulse_abort();

        // Length 0 means full depth, no wrap
        i_trig_mode    = 2'd0;
        i_sample_valid = 1'b1;
        i_length       = 5'd0;
        wq0.delete(); wq1.delete();
        pulse_arm();
        wait_done(0, 60, "s3.done0");
        wait_done(1, 60, "s3.done1");
        cycles(4);
        check("s3.nwrites0", wq0.size(), 16);
        check("s3.order0", seq_errs0(16), 0);
        if (wq0.size() > 0) check("s3.last0", wq0[wq0.size()-1], 15);
        check("s3.nwrites1", wq1.size(), 16);
        check("s3.count0", int'(d0_count), 16);

        // Readout in DONE
        i_rd_req  = 1'b1;
        i_rd_adrs = 4'd7;
        cycles(1);
        i_rd_req  = 1'b0;
        check("s5.rd_en", int'(d0_rd_en), 1);
        check("s5.rd_adrs", int'(d0_rd_adrs), 7);
        check("s5.rd_en1", int'(d1_rd_en), 1);

        // Readout dropped while capturing, then abort after 5 writes
        i_length = 5'd10;
        wq0.delete();
        pulse_arm();
        wait_writes(3, 20, "s4.three");
        i_rd_req = 1'b1;
        cycles(1);
        i_rd_req = 1'b0;
        check("s4.rd_dropped", int'(d0_rd_en), 0);
        wait_writes(5, 20, "s4.five");
        pulse_abort();
        check("s4.idle", int'(d0_state), 0);
        check("s4.count", int'(d0_count), 5);
        check("s4.no_wr", int'(d0_wr_en), 0);
        cycles(5);
        check("s4.frozen", wq0.size(), 5);
        check("s4.count_frozen", int'(d0_count), 5);

        // Asynchronous reset mid-capture, then clean re-arm
        i_length = 5'd8;
        wq0.delete();
        pulse_arm();
        wait_writes(3, 20, "s6.three");
        #2;
        i_reset = 1'b0;
        #1;
        check("s6.state", int'(d0_state), 0);
        check("s6.busy", int'(d0_busy), 0);
        check("s6.done", int'(d0_done), 0);
        check("s6.count", int'(d0_count), 0);
        check("s6.wr_en", int'(d0_wr_en), 0);
        check("s6.wr_adrs", int'(d0_wr_adrs), 0);
        check("s6.rd_adrs", int'(d0_rd_adrs), 0);
        check("s6.state1", int'(d1_state), 0);
        @(negedge clk);
        i_reset = 1'b1;
        cycles(1);
        wq0.delete();
        pulse_arm();
        wait_done(0, 40, "s6.redone");
        check("s6.nwrites", wq0.size(), 8);
        check("s6.order", seq_errs0(8), 0);
        check("s6.recount", int'(d0_count), 8);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            i_arm          = ($urandom_range(0, 15) == 0);
            i_abort        = ($urandom_range(0, 199) == 0);
            i_sample_valid = ($urandom_range(0, 2) != 0);
            i_rd_req       = ($urandom_range(0, 3) == 0);
            i_rd_adrs      = 4'($urandom);
            i_length       = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0)  i_trigger   = ~i_trigger;
            if ($urandom_range(0, 49) == 0) i_trig_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) begin
                #2;
                i_reset = 1'b0;
                @(negedge clk);
                i_reset = 1'b1;
            end
            @(negedge clk);
        end
        i_arm = 1'b0;
        i_abort = 1'b0;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
